// File: rtl/eth_regbank_pkg.sv
// rtl/eth_regbank_pkg.sv - shared constants and types for the Ethernet channel register bank
//
// Purpose: register offsets, response codes, window geometry and the
//          decoded-address record shared by axi_eth_regbank and its bench.
// Ports:   none (package).
package eth_regbank_pkg;

  // Word offsets inside one channel's 16-byte window (addr[3:2]).
  localparam logic [1:0] OFF_STATUS  = 2'd0;
  localparam logic [1:0] OFF_CONTROL = 2'd1;
  localparam logic [1:0] OFF_TXDATA  = 2'd2;
  localparam logic [1:0] OFF_RXDATA  = 2'd3;

  // Byte offsets of the global registers, relative to CH_NUM*CH_STRIDE.
  localparam int GLB_IRQ_PEND = 0;
  localparam int GLB_IRQ_MASK = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CH_STRIDE    = 16;
  localparam int TX_PAYLOAD_W = 10;

  // Result of decoding one AXI word address.
  typedef struct packed {
    logic       ch_hit;    // address falls inside a channel window
    logic       pend_hit;  // IRQ_PEND
    logic       mask_hit;  // IRQ_MASK
    logic [3:0] ch;        // channel index, meaningful only with ch_hit
    logic [1:0] off;       // word offset inside the channel window
  } addr_dec_t;

endpackage

// File: rtl/eth_irq_ctrl.sv
// rtl/eth_irq_ctrl.sv - per-channel pending/mask interrupt controller
//
// Purpose: CH_NUM pending bits set by channel event pulses and cleared by
//          write-one-to-clear, a mask register, and a registered level irq.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   src[CH_NUM]       per-channel event pulses (set PEND)
//   clr[CH_NUM]       W1C clear vector, already qualified by the bus write
//   mask_we           load mask_wdata into MASK
//   mask_wdata        new MASK value (byte-lane merge done by the caller)
//   pend, mask        current PEND / MASK contents
//   irq               registered |(PEND & MASK)
module eth_irq_ctrl #(
  parameter int CH_NUM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] src,
  input  logic [CH_NUM-1:0] clr,
  input  logic              mask_we,
  input  logic [CH_NUM-1:0] mask_wdata,
  output logic [CH_NUM-1:0] pend,
  output logic [CH_NUM-1:0] mask,
  output logic              irq
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      // A new event in the same cycle as its clear must not be lost.
      pend <= (pend & ~clr) | src;
      if (mask_we) begin
        mask <= mask_wdata;
      end
      irq <= |(pend & mask);
    end
  end

endmodule

// File: rtl/axi_eth_regbank.sv
// rtl/axi_eth_regbank.sv - AXI4-Lite register bank for CH_NUM Ethernet protocol channels
//
// Purpose: per-channel STATUS/CONTROL/TXDATA/RXDATA windows of 16 bytes each,
//          followed by global IRQ_PEND (W1C) and IRQ_MASK registers.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_axi_aw*/w*/b*   AXI-Lite write channels (AW and W captured independently)
//   s_axi_ar*/r*      AXI-Lite read channels
//   ch_control        CONTROL contents, ch0 in the LSBs
//   ch_status         per-channel status words
//   ch_tx_data        TXDATA payload {eop,sop,byte}, shared by all channels
//   ch_tx_vld         one-hot single-cycle push strobe
//   ch_rx_data        per-channel RX FIFO heads, 10 bits each
//   ch_rx_rd          one-hot single-cycle pop strobe
//   ch_irq_src        per-channel event pulses
//   irq               level interrupt
module axi_eth_regbank
  import eth_regbank_pkg::*;
#(
  parameter int                      ADDR_WIDTH = 12,
  parameter int                      DATA_WIDTH = 32,
  parameter int                      CH_NUM     = 3,
  parameter logic [CH_NUM*32-1:0]    CTRL_RST   = {32'd5001, 32'd0, 32'd5000}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [CH_NUM*32-1:0]           ch_control,
  input  logic [CH_NUM*32-1:0]           ch_status,
  output logic [TX_PAYLOAD_W-1:0]        ch_tx_data,
  output logic [CH_NUM-1:0]              ch_tx_vld,
  input  logic [CH_NUM*TX_PAYLOAD_W-1:0] ch_rx_data,
  output logic [CH_NUM-1:0]              ch_rx_rd,
  input  logic [CH_NUM-1:0]              ch_irq_src,
  output logic                           irq
);

  localparam int WA_W = ADDR_WIDTH - 2;
  localparam int GLB  = CH_NUM * CH_STRIDE;

  // Decode a word address (byte address with addr[1:0] already dropped).
  function automatic addr_dec_t decode(input logic [WA_W-1:0] wa);
    addr_dec_t d;
    d.off      = wa[1:0];
    d.ch       = wa[5:2];
    d.ch_hit   = wa[WA_W-1:2] < (WA_W-2)'(CH_NUM);
    d.pend_hit = wa == WA_W'((GLB + GLB_IRQ_PEND) / 4);
    d.mask_hit = wa == WA_W'((GLB + GLB_IRQ_MASK) / 4);
    return d;
  endfunction

  // Byte-lane bits are irrelevant: every register is a full word.
  logic [3:0] unused_addr_lsbs;
  assign unused_addr_lsbs = {s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  logic [31:0]       ctrl_q [CH_NUM];
  logic              aw_held, w_held;
  logic [WA_W-1:0]   aw_wa;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [CH_NUM-1:0] irq_pend, irq_mask, irq_clr, mask_wdata;
  logic              do_wr, wr_err, rd_err, mask_we;
  addr_dec_t         wd, rd;
  logic [31:0]       rd_val;

  assign s_axi_awready = !rst && !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !rst && !w_held && !s_axi_bvalid;
  assign s_axi_arready = !rst && !s_axi_rvalid;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ctrl_out
    assign ch_control[32*g +: 32] = ctrl_q[g];
  end

  // Write side: executes the cycle after both address and data are held.
  assign do_wr  = aw_held && w_held;
  assign wd     = decode(aw_wa);
  assign wr_err = !((wd.ch_hit && (wd.off == OFF_CONTROL || wd.off == OFF_TXDATA))
                    || wd.pend_hit || wd.mask_hit);
  assign mask_we = do_wr && wd.mask_hit;

  always_comb begin
    irq_clr    = '0;
    mask_wdata = irq_mask;
    for (int i = 0; i < CH_NUM; i++) begin
      if (w_strb[i/8]) begin
        mask_wdata[i] = w_data[i];
        irq_clr[i]    = do_wr && wd.pend_hit && w_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_wa        <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      ch_tx_vld    <= '0;
      ch_tx_data   <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        ctrl_q[i] <= CTRL_RST[32*i +: 32];
      end
    end else begin
      ch_tx_vld <= '0;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_wa   <= s_axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      // Ready is low while held, so the clear never races a new capture.
      if (do_wr) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        for (int i = 0; i < CH_NUM; i++) begin
          if (wd.ch_hit && wd.ch == 4'(i)) begin
            if (wd.off == OFF_CONTROL) begin
              for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) ctrl_q[i][8*b +: 8] <= w_data[8*b +: 8];
              end
            end
            if (wd.off == OFF_TXDATA && w_strb[0]) begin
              ch_tx_data   <= w_data[TX_PAYLOAD_W-1:0];
              ch_tx_vld[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Read side: response data is captured in the AR handshake cycle.
  assign rd     = decode(s_axi_araddr[ADDR_WIDTH-1:2]);
  assign rd_err = !((rd.ch_hit && rd.off != OFF_TXDATA) || rd.pend_hit || rd.mask_hit);

  always_comb begin
    rd_val = '0;
    if (rd.pend_hit) rd_val = 32'(irq_pend);
    if (rd.mask_hit) rd_val = 32'(irq_mask);
    for (int i = 0; i < CH_NUM; i++) begin
      if (rd.ch_hit && rd.ch == 4'(i)) begin
        case (rd.off)
          OFF_STATUS:  rd_val = ch_status[32*i +: 32];
          OFF_CONTROL: rd_val = ctrl_q[i];
          OFF_RXDATA:  rd_val = 32'(ch_rx_data[TX_PAYLOAD_W*i +: TX_PAYLOAD_W]);
          default:     rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
      ch_rx_rd     <= '0;
    end else begin
      ch_rx_rd <= '0;
      if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        s_axi_rdata  <= rd_err ? '0 : rd_val;
        for (int i = 0; i < CH_NUM; i++) begin
          if (rd.ch_hit && rd.ch == 4'(i) && rd.off == OFF_RXDATA) ch_rx_rd[i] <= 1'b1;
        end
      end
    end
  end

  eth_irq_ctrl #(.CH_NUM(CH_NUM)) u_irq (
    .clk       (clk),
    .rst       (rst),
    .src       (ch_irq_src),
    .clr       (irq_clr),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .pend      (irq_pend),
    .mask      (irq_mask),
    .irq       (irq)
  );

endmodule
